// File: rtl/pmp_csr_regfile_pkg.sv
// Shared types, CSR addresses and helpers for the PMP configuration register file.
// A-field and CSR op encodings follow the RISC-V privileged architecture.
package pmp_csr_regfile_pkg;

    typedef enum logic [1:0] {
        PMP_OFF   = 2'd0,
        PMP_TOR   = 2'd1,
        PMP_NA4   = 2'd2,
        PMP_NAPOT = 2'd3
    } pmp_a_e;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_e;

    localparam logic [11:0] PMPCFG0      = 12'h3A0;
    localparam logic [11:0] PMPADDR0     = 12'h3B0;
    localparam logic [31:0] PMP_MASK_RST = 32'hFFFF_FFFC;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_a_e     a;
        logic       x;
        logic       w;
        logic       r;
    } pmp_cfg_t;

    // Byte-scale compare mask: clears the trailing-ones run of {addr,2'b11}.
    function automatic logic [31:0] napot_mask(input logic [29:0] addr);
        logic [31:0] word;
        word = {addr, 2'b11};
        return ~(word & ~(word + 32'd1));
    endfunction

    // Reserved bits read zero and the reserved R=0,W=1 combination drops W.
    function automatic pmp_cfg_t cfg_warl(input pmp_cfg_t cfg);
        pmp_cfg_t res;
        res      = cfg;
        res.rsvd = 2'b00;
        if (!cfg.r && cfg.w) begin
            res.w = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/pmp_csr_regfile_if.sv
// CSR request/response bus between the CSR file (master) and the PMP register file (slave).
interface pmp_csr_regfile_if;

    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_rvalid;
    logic [31:0] csr_rdata;
    logic        csr_err;

    modport master (
        output csr_valid,
        output csr_op,
        output csr_addr,
        output csr_wdata,
        input  csr_rvalid,
        input  csr_rdata,
        input  csr_err
    );

    modport slave (
        input  csr_valid,
        input  csr_op,
        input  csr_addr,
        input  csr_wdata,
        output csr_rvalid,
        output csr_rdata,
        output csr_err
    );

endinterface

// File: rtl/pmp_csr_regfile_entry.sv
// One PMP entry: cfg byte, pmpaddr and its NAPOT mask, with WARL and lock rules applied locally.
// Lock decisions use the registered cfg, so a write that sets L only affects later writes.
module pmp_csr_regfile_entry
    import pmp_csr_regfile_pkg::*;
#(
    parameter int ADDR_W = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_cfg,
    input  logic              wr_addr,
    input  pmp_cfg_t          cfg_new,
    input  logic [ADDR_W-1:0] addr_new,
    input  logic              lock_next_tor,
    output pmp_cfg_t          cfg_q,
    output logic [ADDR_W-1:0] addr_q,
    output logic [31:0]       mask_q
);

    pmp_cfg_t          cfg_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       mask_d;
    logic [29:0]       addr_ext;

    always_comb begin
        cfg_d = cfg_q;
        if (wr_cfg && !cfg_q.l) begin
            cfg_d = cfg_warl(cfg_new);
        end

        addr_d = addr_q;
        if (wr_addr && !cfg_q.l && !lock_next_tor) begin
            addr_d = addr_new;
        end

        // Mask follows the post-write address so pmp_addr and pmp_mask never disagree.
        addr_ext                = '0;
        addr_ext[ADDR_W-1:0]    = addr_d;
        mask_d                  = napot_mask(addr_ext);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_q  <= '0;
            addr_q <= '0;
            mask_q <= PMP_MASK_RST;
        end else begin
            cfg_q  <= cfg_d;
            addr_q <= addr_d;
            mask_q <= mask_d;
        end
    end

endmodule

// File: rtl/pmp_csr_regfile.sv
// PMP CSR register file: decodes pmpcfg0/pmpaddr accesses, performs read-modify-write and
// returns the pre-modify value one cycle later; feeds registered cfg/addr/mask to the checker.
module pmp_csr_regfile
    import pmp_csr_regfile_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int ADDR_W      = 30
) (
    input  logic                          clock,
    input  logic                          reset,
    pmp_csr_regfile_if.slave              csr,
    output logic [8*NUM_ENTRIES-1:0]      pmp_cfg,
    output logic [ADDR_W*NUM_ENTRIES-1:0] pmp_addr,
    output logic [32*NUM_ENTRIES-1:0]     pmp_mask
);

    pmp_cfg_t          cfg_q  [NUM_ENTRIES];
    logic [ADDR_W-1:0] addr_q [NUM_ENTRIES];
    logic [31:0]       mask_q [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] wr_addr;
    logic [NUM_ENTRIES-1:0] lock_next_tor;
    logic                   is_cfg;
    logic                   is_addr;
    logic                   wr_en;
    logic                   wr_cfg;
    logic [1:0]             idx;
    logic [31:0]            old_val;
    logic [31:0]            new_val;

    logic        rvalid_d, rvalid_q;
    logic        err_d,    err_q;
    logic [31:0] rdata_d,  rdata_q;

    assign idx     = csr.csr_addr[1:0];
    assign is_cfg  = (csr.csr_addr == PMPCFG0);
    assign is_addr = (csr.csr_addr[11:2] == PMPADDR0[11:2]) && ({1'b0, idx} < 3'(NUM_ENTRIES));
    assign wr_en   = csr.csr_valid && (csr.csr_op != CSR_OP_READ);
    assign wr_cfg  = wr_en && is_cfg;

    // Pre-modify value; unimplemented cfg bytes and pmpaddr bits above ADDR_W read as zero.
    always_comb begin
        old_val = '0;
        if (is_cfg) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                old_val[8*i +: 8] = cfg_q[i];
            end
        end else if (is_addr) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (idx == 2'(i)) begin
                    old_val[ADDR_W-1:0] = addr_q[i];
                end
            end
        end
    end

    always_comb begin
        case (csr.csr_op)
            CSR_OP_SET:   new_val = old_val | csr.csr_wdata;
            CSR_OP_CLEAR: new_val = old_val & ~csr.csr_wdata;
            default:      new_val = csr.csr_wdata;
        endcase
    end

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
        assign wr_addr[i] = wr_en && is_addr && (idx == 2'(i));

        // A locked TOR entry also protects the address below it, its range base.
        if (i + 1 < NUM_ENTRIES) begin : g_tor
            assign lock_next_tor[i] = cfg_q[i+1].l && (cfg_q[i+1].a == PMP_TOR);
        end else begin : g_last
            assign lock_next_tor[i] = 1'b0;
        end

        pmp_csr_regfile_entry #(
            .ADDR_W (ADDR_W)
        ) u_entry (
            .clock         (clock),
            .reset         (reset),
            .wr_cfg        (wr_cfg),
            .wr_addr       (wr_addr[i]),
            .cfg_new       (pmp_cfg_t'(new_val[8*i +: 8])),
            .addr_new      (new_val[ADDR_W-1:0]),
            .lock_next_tor (lock_next_tor[i]),
            .cfg_q         (cfg_q[i]),
            .addr_q        (addr_q[i]),
            .mask_q        (mask_q[i])
        );

        assign pmp_cfg[8*i +: 8]          = cfg_q[i];
        assign pmp_addr[ADDR_W*i +: ADDR_W] = addr_q[i];
        assign pmp_mask[32*i +: 32]        = mask_q[i];
    end

    always_comb begin
        rvalid_d = csr.csr_valid;
        err_d    = csr.csr_valid && !is_cfg && !is_addr;
        rdata_d  = csr.csr_valid ? old_val : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign csr.csr_rvalid = rvalid_q;
    assign csr.csr_err    = err_q;
    assign csr.csr_rdata  = rdata_q;

endmodule

// File: tb/tb_pmp_csr_regfile.sv
// Self-checking bench for pmp_csr_regfile: behavioural model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_pmp_csr_regfile;

    localparam int N  = 4;
    localparam int AW = 30;

    logic            clock = 1'b0;
    logic            reset;
    logic [8*N-1:0]  pmp_cfg;
    logic [AW*N-1:0] pmp_addr;
    logic [32*N-1:0] pmp_mask;

    int checks   = 0;
    int failures = 0;

    pmp_csr_regfile_if csr_if();

    pmp_csr_regfile #(
        .NUM_ENTRIES (N),
        .ADDR_W      (AW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .csr      (csr_if),
        .pmp_cfg  (pmp_cfg),
        .pmp_addr (pmp_addr),
        .pmp_mask (pmp_mask)
    );

    always #5 clock = ~clock;

    logic [7:0]  m_cfg  [N];
    logic [31:0] m_addr [N];
    logic        exp_rvalid;
    logic        exp_err;
    logic [31:0] exp_rdata;
    bit          model_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Size of the trailing-ones run of {addr,2'b11} defines the masked low bits.
    function automatic logic [31:0] model_mask(input logic [31:0] a);
        int t;
        t = 0;
        while (t < 30 && a[t]) t++;
        if (t + 2 >= 32) return 32'h0;
        return ~((32'd1 << (t + 2)) - 32'd1);
    endfunction

    task automatic model_step();
        logic [31:0] old_v;
        logic [31:0] nv;
        logic [7:0]  b;
        logic        locked;
        int          k;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_cfg[i]  = 8'h00;
                m_addr[i] = 32'h0;
            end
            exp_rvalid  = 1'b0;
            exp_err     = 1'b0;
            exp_rdata   = 32'h0;
            model_ready = 1'b1;
            return;
        end
        exp_rvalid = csr_if.csr_valid;
        exp_err    = 1'b0;
        exp_rdata  = 32'h0;
        if (!csr_if.csr_valid) return;
        k     = int'(csr_if.csr_addr) - 'h3B0;
        old_v = 32'h0;
        if (csr_if.csr_addr == 12'h3A0) begin
            for (int i = 0; i < N; i++) old_v = old_v | (32'(m_cfg[i]) << (8 * i));
        end else if (k >= 0 && k < N) begin
            old_v = m_addr[k];
        end else begin
            exp_err = 1'b1;
            return;
        end
        exp_rdata = old_v;
        case (csr_if.csr_op)
            2'd1:    nv = csr_if.csr_wdata;
            2'd2:    nv = old_v | csr_if.csr_wdata;
            2'd3:    nv = old_v & ~csr_if.csr_wdata;
            default: return;
        endcase
        if (csr_if.csr_addr == 12'h3A0) begin
            for (int i = 0; i < N; i++) begin
                if (!m_cfg[i][7]) begin
                    b      = nv[8*i +: 8];
                    b[6:5] = 2'b00;
                    if (b[1:0] == 2'b10) b[1] = 1'b0;
                    m_cfg[i] = b;
                end
            end
        end else begin
            locked = m_cfg[k][7];
            if (k + 1 < N) begin
                if (m_cfg[k+1][7] && m_cfg[k+1][4:3] == 2'b01) locked = 1'b1;
            end
            if (!locked) m_addr[k] = nv & 32'((64'd1 << AW) - 64'd1);
        end
    endtask

    always @(posedge clock) model_step();

    always @(negedge clock) begin
        if (model_ready) begin
            check("rvalid", 32'(csr_if.csr_rvalid), 32'(exp_rvalid));
            check("err", 32'(csr_if.csr_err), 32'(exp_err));
            if (exp_rvalid) check("rdata", csr_if.csr_rdata, exp_rdata);
            for (int i = 0; i < N; i++) begin
                check($sformatf("cfg%0d", i), 32'(pmp_cfg[8*i +: 8]), 32'(m_cfg[i]));
                check($sformatf("addr%0d", i), 32'(pmp_addr[AW*i +: AW]), m_addr[i]);
                check($sformatf("mask%0d", i), pmp_mask[32*i +: 32], model_mask(m_addr[i]));
            end
        end
    end

    task automatic req(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_if.csr_valid = 1'b1;
        csr_if.csr_op    = op;
        csr_if.csr_addr  = a;
        csr_if.csr_wdata = d;
        @(posedge clock);
        #1;
        csr_if.csr_valid = 1'b0;
        @(negedge clock);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
        req(2'd0, a, 32'h0);
        check({name, "_rvalid"}, 32'(csr_if.csr_rvalid), 32'h1);
        check(name, csr_if.csr_rdata, exp);
    endtask

    initial begin
        csr_if.csr_valid = 1'b0;
        csr_if.csr_op    = 2'd0;
        csr_if.csr_addr  = 12'h0;
        csr_if.csr_wdata = 32'h0;
        reset            = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b0;

        check("rst_mask0", pmp_mask[31:0], 32'hFFFF_FFFC);
        check("rst_cfg", pmp_cfg, 32'h0);
        check("rst_rvalid", 32'(csr_if.csr_rvalid), 32'h0);
        rd(12'h3A0, 32'h0, "rd_cfg_rst");
        rd(12'h3B0, 32'h0, "rd_addr0_rst");

        req(2'd1, 12'h3B1, 32'h0000_0FFF);
        check("mask1_napot", pmp_mask[63:32], 32'hFFFF_C000);
        req(2'd1, 12'h3A0, 32'h0000_1F00);
        check("cfg1_napot", 32'(pmp_cfg[15:8]), 32'h1F);
        rd(12'h3A0, 32'h0000_1F00, "rd_cfg_1f00");

        req(2'd1, 12'h3A0, 32'h0000_0002);
        rd(12'h3A0, 32'h0, "warl_w_only");
        req(2'd1, 12'h3A0, 32'h0000_007F);
        rd(12'h3A0, 32'h0000_001F, "rsvd_zero");
        req(2'd1, 12'h3A0, 32'h0000_0089);
        rd(12'h3A0, 32'h0000_0089, "lock_set");

        req(2'd1, 12'h3B0, 32'h0000_0123);
        rd(12'h3B0, 32'h0, "addr0_locked");
        req(2'd1, 12'h3B1, 32'h0000_0456);
        rd(12'h3B1, 32'h0000_0456, "addr1_free");
        check("mask1_even", pmp_mask[63:32], 32'hFFFF_FFFC);

        req(2'd3, 12'h3A0, 32'h0000_00FF);
        check("rc_rdata", csr_if.csr_rdata, 32'h0000_0089);
        rd(12'h3A0, 32'h0000_0089, "rc_locked");

        req(2'd2, 12'h3A0, 32'h0000_8800);
        check("rs_cfg1_rdata", csr_if.csr_rdata, 32'h0000_0089);
        rd(12'h3A0, 32'h0000_8889, "cfg1_lock_tor");
        req(2'd1, 12'h3B0, 32'h0000_0055);
        rd(12'h3B0, 32'h0, "addr0_still_locked");

        req(2'd1, 12'h3B2, 32'hFFFF_FFFF);
        rd(12'h3B2, 32'h3FFF_FFFF, "addr_upper_zero");
        check("mask2_all_ones", pmp_mask[95:64], 32'h0);
        req(2'd1, 12'h3B2, 32'h0000_03FF);
        check("mask2_3ff", pmp_mask[95:64], 32'hFFFF_F000);

        req(2'd2, 12'h3A0, 32'h0100_0000);
        check("rs_old_value", csr_if.csr_rdata, 32'h0000_8889);
        check("rs_byte3_r", 32'(pmp_cfg[31:24]), 32'h01);
        req(2'd2, 12'h3A0, 32'h8800_0000);
        rd(12'h3A0, 32'h8900_8889, "cfg3_lock_tor");
        req(2'd1, 12'h3B2, 32'h0000_0012);
        rd(12'h3B2, 32'h0000_03FF, "addr2_tor_locked");
        req(2'd1, 12'h3B3, 32'h0000_0005);
        rd(12'h3B3, 32'h0, "addr3_locked");
        req(2'd1, 12'h3A0, 32'h001E_0000);
        rd(12'h3A0, 32'h891C_8889, "warl_keep_xa");

        req(2'd0, 12'h3A1, 32'h0);
        check("err_pulse", 32'(csr_if.csr_err), 32'h1);
        check("err_rdata", csr_if.csr_rdata, 32'h0);
        @(negedge clock);
        #1;
        check("err_pulse_end", 32'(csr_if.csr_err), 32'h0);
        req(2'd1, 12'h3B4, 32'hDEAD_BEEF);
        check("err_wr_oob", 32'(csr_if.csr_err), 32'h1);
        rd(12'h3B2, 32'h0000_03FF, "err_no_change");
        rd(12'h3A0, 32'h891C_8889, "err_no_cfg_change");

        reset            = 1'b1;
        csr_if.csr_valid = 1'b1;
        csr_if.csr_op    = 2'd1;
        csr_if.csr_addr  = 12'h3B2;
        csr_if.csr_wdata = 32'h0000_0077;
        @(posedge clock);
        #1;
        reset            = 1'b0;
        csr_if.csr_valid = 1'b0;
        @(negedge clock);
        #1;
        check("rst_drop_rvalid", 32'(csr_if.csr_rvalid), 32'h0);
        check("rst_clear_lock", pmp_cfg, 32'h0);
        check("rst_clear_addr2", 32'(pmp_addr[89:60]), 32'h0);
        rd(12'h3A0, 32'h0, "post_rst_cfg");
        req(2'd1, 12'h3B0, 32'h0000_0ABC);
        rd(12'h3B0, 32'h0000_0ABC, "post_rst_unlocked");

        repeat (2) @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
